// File: rtl/rx_os_pkg.sv
// rx_os_pkg: shared encodings for the RX ordered-set counters.
// OS type codes, TS field layout and the field-compare helper.
package rx_os_pkg;

  typedef enum logic [1:0] {
    OS_TS1   = 2'd0,
    OS_TS2   = 2'd1,
    OS_EIEOS = 2'd2,
    OS_SKP   = 2'd3
  } osType_e;

  // expectedOs value meaning "no OS expected"; shares the SKP code.
  localparam logic [1:0] OS_NONE = 2'd3;

  localparam int FIELD_W     = 8;
  localparam int OS_FIELDS_W = 32;
  localparam int LINK_LSB    = 0;
  localparam int LANE_LSB    = 8;
  localparam int RATE_LSB    = 16;
  localparam int CTRL_LSB    = 24;

  typedef struct packed {
    logic [FIELD_W-1:0] ctrl;
    logic [FIELD_W-1:0] rate;
    logic [FIELD_W-1:0] lane;
    logic [FIELD_W-1:0] link;
  } tsFields_t;

  // Unpack a raw 32-bit slice into named TS symbols.
  function automatic tsFields_t unpackFields(
    input logic [OS_FIELDS_W-1:0] raw
  );
    tsFields_t f;
    f.link = raw[LINK_LSB +: FIELD_W];
    f.lane = raw[LANE_LSB +: FIELD_W];
    f.rate = raw[RATE_LSB +: FIELD_W];
    f.ctrl = raw[CTRL_LSB +: FIELD_W];
    return f;
  endfunction

  // EIEOS carries no negotiable content, so any two match.
  function automatic logic fieldsMatch(
    input logic [1:0] osType,
    input tsFields_t  a,
    input tsFields_t  b
  );
    return (osType == OS_EIEOS) || (a == b);
  endfunction

endpackage

// File: rtl/rx_os_lane_counter.sv
// rx_os_lane_counter: one lane's consecutive-OS counter.
// Holds the count, the last stored TS fields and the reached flag.
module rx_os_lane_counter
  import rx_os_pkg::*;
#(
  parameter int CNTW = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [CNTW-1:0]        comparatorsCount,
  input  logic [1:0]             expectedOs,
  input  logic                   osValid,
  input  logic [1:0]             osType,
  input  logic [OS_FIELDS_W-1:0] osFields,
  output logic                   countReached,
  output logic [OS_FIELDS_W-1:0] fieldsOut
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [CNTW-1:0] count;
  logic [CNTW-1:0] countNext;
  tsFields_t       stored;
  tsFields_t       storedNext;
  tsFields_t       inFields;
  logic            reachedNext;
  logic            typeHit;
  logic            sameContent;

  assign inFields    = unpackFields(osFields);
  assign typeHit     = (osType == expectedOs);
  assign sameContent = fieldsMatch(osType, inFields, stored);

  // Next count/fields in priority order; SKP and idle cycles hold.
  always_comb begin
    countNext  = count;
    storedNext = stored;
    if (!enable) begin
      countNext  = '0;
      storedNext = '0;
    end else if (!osValid) begin
      countNext = count;
    end else if (osType == OS_SKP) begin
      countNext = count;
    end else if (expectedOs == OS_NONE) begin
      countNext = count;
    end else if (typeHit) begin
      storedNext = inFields;
      if ((count == '0) || sameContent) begin
        countNext = (count == CNT_MAX) ? count : count + CNT_ONE;
      end else begin
        countNext = CNT_ONE;
      end
    end else begin
      countNext = '0;
    end
    reachedNext = enable && (countNext >= comparatorsCount);
  end

  // State registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      stored       <= '0;
      countReached <= 1'b0;
    end else begin
      count        <= countNext;
      stored       <= storedNext;
      countReached <= reachedNext;
    end
  end

  assign fieldsOut = stored;

endmodule

// File: rtl/rx_os_counter.sv
// rx_os_counter: per-lane TS1/TS2 consistency counters for the RX LTSSM.
// One independent rx_os_lane_counter per lane plus port slicing.
module rx_os_counter
  import rx_os_pkg::*;
#(
  parameter int MAXLANES = 16,
  parameter int CNTW     = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [MAXLANES-1:0]             resetOsCheckers,
  input  logic [CNTW-1:0]                 comparatorsCount,
  input  logic [1:0]                      expectedOs,
  input  logic [MAXLANES-1:0]             osValid,
  input  logic [2*MAXLANES-1:0]           osType,
  input  logic [OS_FIELDS_W*MAXLANES-1:0] osFields,
  output logic [MAXLANES-1:0]             countersComparators,
  output logic [OS_FIELDS_W*MAXLANES-1:0] osFieldsOut
);

  for (genvar i = 0; i < MAXLANES; i++) begin : gLane
    rx_os_lane_counter #(
      .CNTW(CNTW)
    ) uLane (
      .clk             (clk),
      .reset           (reset),
      .enable          (resetOsCheckers[i]),
      .comparatorsCount(comparatorsCount),
      .expectedOs      (expectedOs),
      .osValid         (osValid[i]),
      .osType          (osType[2*i +: 2]),
      .osFields        (osFields[OS_FIELDS_W*i +: OS_FIELDS_W]),
      .countReached    (countersComparators[i]),
      .fieldsOut       (osFieldsOut[OS_FIELDS_W*i +: OS_FIELDS_W])
    );
  end

endmodule

// File: tb/tb_rx_os_counter.sv
// tb_rx_os_counter: directed scenarios for rx_os_counter.
// Count is inferred from the flag by sweeping comparatorsCount.
module tb_rx_os_counter;

  localparam int L = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [L-1:0]    resetOsCheckers;
  logic [4:0]      comparatorsCount;
  logic [1:0]      expectedOs;
  logic [L-1:0]    osValid;
  logic [2*L-1:0]  osType;
  logic [32*L-1:0] osFields;
  logic [L-1:0]    countersComparators;
  logic [32*L-1:0] osFieldsOut;

  int errors = 0;
  int checks = 0;

  rx_os_counter #(.MAXLANES(L), .CNTW(5)) dut (
    .clk                (clk),
    .reset              (reset),
    .resetOsCheckers    (resetOsCheckers),
    .comparatorsCount   (comparatorsCount),
    .expectedOs         (expectedOs),
    .osValid            (osValid),
    .osType             (osType),
    .osFields           (osFields),
    .countersComparators(countersComparators),
    .osFieldsOut        (osFieldsOut)
  );

  always #5 clk = ~clk;

  task automatic sendOs(input int lane, input logic [1:0] t,
                        input logic [31:0] f);
    @(negedge clk);
    osValid = '0;
    osValid[lane] = 1'b1;
    osType[2*lane +: 2] = t;
    osFields[32*lane +: 32] = f;
    @(negedge clk);
    osValid = '0;
  endtask

  task automatic expectCount(input int lane, input int exp,
                             input string name);
    logic [4:0] save;
    save = comparatorsCount;
    comparatorsCount = 5'(exp);
    @(negedge clk);
    checks++;
    if (countersComparators[lane] !== 1'b1) begin
      errors++;
      $display("FAIL %s: lane %0d count below %0d (flag=%b, want 1)",
               name, lane, exp, countersComparators[lane]);
    end
    if (exp < 31) begin
      comparatorsCount = 5'(exp + 1);
      @(negedge clk);
      checks++;
      if (countersComparators[lane] !== 1'b0) begin
        errors++;
        $display("FAIL %s: lane %0d count above %0d (flag=%b, want 0)",
                 name, lane, exp, countersComparators[lane]);
      end
    end
    comparatorsCount = save;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    resetOsCheckers = '1;
    comparatorsCount = 5'd0;
    expectedOs = 2'd0;
    osValid = '0;
    osType = '0;
    osFields = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (countersComparators !== '0) begin
      errors++;
      $display("FAIL reset_flags: got %h want 0", countersComparators);
    end
    checks++;
    if (osFieldsOut !== '0) begin
      errors++;
      $display("FAIL reset_fields: got %h want 0", osFieldsOut);
    end
    reset = 1'b0;
    comparatorsCount = 5'd31;
    repeat (5) sendOs(0, 2'd0, 32'h11223344);
    expectCount(0, 5, "pre_reset_count");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (countersComparators !== '0) begin
      errors++;
      $display("FAIL midreset_flags: got %h want 0", countersComparators);
    end
    checks++;
    if (osFieldsOut !== '0) begin
      errors++;
      $display("FAIL midreset_fields: got %h want 0", osFieldsOut);
    end
    expectCount(0, 0, "midreset_count");
  endtask

  task automatic test_basic_reach();
    comparatorsCount = 5'd8;
    expectedOs = 2'd0;
    for (int i = 0; i < 7; i++) sendOs(3, 2'd0, 32'h00020301);
    checks++;
    if (countersComparators[3] !== 1'b0) begin
      errors++;
      $display("FAIL basic_7: flag=%b want 0", countersComparators[3]);
    end
    sendOs(3, 2'd0, 32'h00020301);
    checks++;
    if (countersComparators[3] !== 1'b1) begin
      errors++;
      $display("FAIL basic_8: flag=%b want 1", countersComparators[3]);
    end
    checks++;
    if (osFieldsOut[32*3 +: 32] !== 32'h00020301) begin
      errors++;
      $display("FAIL basic_fields: got %h want 00020301",
               osFieldsOut[32*3 +: 32]);
    end
    repeat (2) sendOs(3, 2'd0, 32'h00020301);
    checks++;
    if (countersComparators[3] !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold: flag=%b want 1", countersComparators[3]);
    end
    expectCount(3, 10, "basic_count");
  endtask

  task automatic test_content_change();
    comparatorsCount = 5'd2;
    expectedOs = 2'd1;
    sendOs(2, 2'd1, 32'h00020201);
    expectCount(2, 1, "change_a");
    sendOs(2, 2'd1, 32'h00020301);
    checks++;
    if (countersComparators[2] !== 1'b0) begin
      errors++;
      $display("FAIL change_b_flag: flag=%b want 0", countersComparators[2]);
    end
    expectCount(2, 1, "change_b");
    sendOs(2, 2'd1, 32'h00020301);
    checks++;
    if (countersComparators[2] !== 1'b1) begin
      errors++;
      $display("FAIL change_bb_flag: flag=%b want 1", countersComparators[2]);
    end
    checks++;
    if (osFieldsOut[32*2 +: 32] !== 32'h00020301) begin
      errors++;
      $display("FAIL change_fields: got %h want 00020301",
               osFieldsOut[32*2 +: 32]);
    end
  endtask

  task automatic test_skp_mismatch();
    comparatorsCount = 5'd2;
    expectedOs = 2'd0;
    sendOs(4, 2'd0, 32'h0A0B0C0D);
    sendOs(4, 2'd3, 32'hFFFFFFFF);
    sendOs(4, 2'd0, 32'h0A0B0C0D);
    checks++;
    if (countersComparators[4] !== 1'b1) begin
      errors++;
      $display("FAIL skp_flag: flag=%b want 1", countersComparators[4]);
    end
    expectCount(4, 2, "skp_count");
    sendOs(4, 2'd1, 32'h55555555);
    checks++;
    if (countersComparators[4] !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_flag: flag=%b want 0", countersComparators[4]);
    end
    checks++;
    if (osFieldsOut[32*4 +: 32] !== 32'h0A0B0C0D) begin
      errors++;
      $display("FAIL mismatch_fields: got %h want 0A0B0C0D",
               osFieldsOut[32*4 +: 32]);
    end
    expectCount(4, 0, "mismatch_count");
  endtask

  task automatic test_eieos();
    comparatorsCount = 5'd3;
    expectedOs = 2'd2;
    sendOs(6, 2'd2, 32'h00000001);
    sendOs(6, 2'd2, 32'h00000002);
    sendOs(6, 2'd2, 32'h00000003);
    checks++;
    if (countersComparators[6] !== 1'b1) begin
      errors++;
      $display("FAIL eieos_flag: flag=%b want 1", countersComparators[6]);
    end
    expectedOs = 2'd3;
    sendOs(7, 2'd0, 32'h12345678);
    expectCount(7, 0, "none_count");
  endtask

  task automatic test_enable();
    comparatorsCount = 5'd1;
    expectedOs = 2'd0;
    resetOsCheckers[5] = 1'b0;
    repeat (10) sendOs(5, 2'd0, 32'h00020501);
    checks++;
    if (countersComparators[5] !== 1'b0) begin
      errors++;
      $display("FAIL gated_flag: flag=%b want 0", countersComparators[5]);
    end
    checks++;
    if (osFieldsOut[32*5 +: 32] !== 32'h0) begin
      errors++;
      $display("FAIL gated_fields: got %h want 0", osFieldsOut[32*5 +: 32]);
    end
    comparatorsCount = 5'd0;
    resetOsCheckers[5] = 1'b1;
    @(negedge clk);
    checks++;
    if (countersComparators[5] !== 1'b1) begin
      errors++;
      $display("FAIL enable_rise: flag=%b want 1", countersComparators[5]);
    end
    resetOsCheckers[5] = 1'b0;
    @(negedge clk);
    checks++;
    if (countersComparators[5] !== 1'b0) begin
      errors++;
      $display("FAIL enable_fall: flag=%b want 0", countersComparators[5]);
    end
    resetOsCheckers[5] = 1'b1;
  endtask

  task automatic test_saturation();
    comparatorsCount = 5'd31;
    expectedOs = 2'd0;
    for (int i = 0; i < 30; i++) sendOs(0, 2'd0, 32'h00020001);
    checks++;
    if (countersComparators[0] !== 1'b0) begin
      errors++;
      $display("FAIL sat_30: flag=%b want 0", countersComparators[0]);
    end
    sendOs(0, 2'd0, 32'h00020001);
    checks++;
    if (countersComparators[0] !== 1'b1) begin
      errors++;
      $display("FAIL sat_31: flag=%b want 1", countersComparators[0]);
    end
    for (int i = 0; i < 9; i++) sendOs(0, 2'd0, 32'h00020001);
    checks++;
    if (countersComparators[0] !== 1'b1) begin
      errors++;
      $display("FAIL sat_40: flag=%b want 1", countersComparators[0]);
    end
    expectCount(0, 31, "sat_count");
    checks++;
    if (osFieldsOut[32*1 +: 32] !== 32'h0) begin
      errors++;
      $display("FAIL idle_fields: got %h want 0", osFieldsOut[32*1 +: 32]);
    end
    expectCount(1, 0, "idle_count");
  endtask

  initial begin
    test_reset();
    test_basic_reach();
    test_content_change();
    test_skp_mismatch();
    test_eieos();
    test_enable();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
